// File: rtl/sd_pkg.sv
// Shared types, constants and helpers for the 8b/10b receive comma aligner.
package sd_pkg;

  localparam int SD_SYM_W  = 10;
  localparam int SD_ONES_W = $clog2(SD_SYM_W + 1);

  localparam logic [SD_SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SD_SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} sd_state_e;

  function automatic logic [SD_ONES_W-1:0] ones_cnt(input logic [SD_SYM_W-1:0] sym);
    logic [SD_ONES_W-1:0] n;
    n = '0;
    for (int i = 0; i < SD_SYM_W; i++) n = n + SD_ONES_W'(sym[i]);
    return n;
  endfunction

endpackage

// File: rtl/sd_disp_check.sv
// Running-disparity tracker for emitted 10b symbols; flags symbols whose
// ones-count is illegal for the current running disparity.
module sd_disp_check
  import sd_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Chk,
  input  logic                i_Acq,
  input  logic [SD_SYM_W-1:0] i_Sym,
  output logic                o_Err
);

  logic                 rd_pos_q, rd_pos_d;
  logic [SD_ONES_W-1:0] ones;
  logic                 unbalanced;

  always_comb begin
    ones       = ones_cnt(i_Sym);
    unbalanced = (ones == SD_ONES_W'(4)) || (ones == SD_ONES_W'(6));
    o_Err      = i_Chk && !((ones == SD_ONES_W'(5)) ||
                            ((ones == SD_ONES_W'(6)) && !rd_pos_q) ||
                            ((ones == SD_ONES_W'(4)) &&  rd_pos_q));
    rd_pos_d   = rd_pos_q;
    // Acquisition seeds RD from the comma itself: 6 ones leaves the line positive.
    if (i_Acq)                    rd_pos_d = (ones == SD_ONES_W'(6));
    else if (i_Chk && unbalanced) rd_pos_d = ~rd_pos_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) rd_pos_q <= 1'b0;
    else          rd_pos_q <= rd_pos_d;
  end

endmodule

// File: rtl/sd_comma_aligner.sv
// Serial-to-10b symbol aligner: hunts for K28.5, locks symbol phase, drops lock
// on repeated misalignment. Define SD_RD_CHECK_EN to add running-disparity checking.
module sd_comma_aligner
  import sd_pkg::*;
#(
  parameter int               SYM_W    = SD_SYM_W,
  parameter logic [SYM_W-1:0] COMMA    = K28_5_RDN,
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Bit,
  input  logic             i_Bit_Valid,
  output logic [SYM_W-1:0] o_Sym,
  output logic             o_Sym_Valid,
  output logic             o_Is_Comma,
  output logic             o_Lock,
  output logic             o_Realign,
  output logic             o_Disp_Err
);

  localparam int PH_W = $clog2(SYM_W);
  localparam int CC_W = $clog2(LOCK_CNT + 1);
  localparam int EC_W = $clog2(LOSS_CNT + 1);

  sd_state_e        state_q, state_d;
  logic [SYM_W-2:0] sr_q, sr_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [EC_W-1:0]  err_cnt_q, err_cnt_d;

  logic [SYM_W-1:0] sym_q;
  logic             sym_valid_q, is_comma_q, lock_q, realign_q, disp_err_q;

  logic [SYM_W-1:0] win;
  logic             match, boundary, emit, acq, realign, disp_err;

  always_comb begin
    win      = {sr_q, i_Bit};
    match    = (win == COMMA) || (win == ~COMMA);
    boundary = (ph_q == PH_W'(SYM_W - 1));
    acq      = i_Bit_Valid && (state_q == HUNT) && match;
    realign  = acq || (i_Bit_Valid && (state_q == SYNC) && !boundary && match);
    unique case (state_q)
      HUNT:    emit = i_Bit_Valid && match;
      SYNC:    emit = i_Bit_Valid && (boundary || match);
      LOCKED:  emit = i_Bit_Valid && boundary;
      default: emit = 1'b0;
    endcase
  end

`ifdef SD_RD_CHECK_EN
  logic chk;
  assign chk = emit && !acq;

  sd_disp_check u_disp_check (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Chk   (chk),
    .i_Acq   (acq),
    .i_Sym   (win),
    .o_Err   (disp_err)
  );
`else
  assign disp_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path infers a latch.
    state_d     = state_q;
    sr_d        = sr_q;
    ph_d        = ph_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (i_Bit_Valid) begin
      sr_d = win[SYM_W-2:0];
      ph_d = boundary ? '0 : ph_q + 1'b1;
      unique case (state_q)
        HUNT: begin
          if (match) begin
            ph_d        = '0;
            comma_cnt_d = CC_W'(1);
            state_d     = SYNC;
          end
        end
        SYNC: begin
          if (boundary && match) begin
            if (comma_cnt_q != CC_W'(LOCK_CNT)) comma_cnt_d = comma_cnt_q + 1'b1;
            if (comma_cnt_d == CC_W'(LOCK_CNT)) begin
              state_d   = LOCKED;
              err_cnt_d = '0;
            end
          end else if (match) begin
            ph_d        = '0;
            comma_cnt_d = CC_W'(1);
          end
        end
        LOCKED: begin
          // Misaligned commas only count as errors here; phase is never moved while locked.
          if (boundary && match) err_cnt_d = '0;
          else if ((match || disp_err) && (err_cnt_q != EC_W'(LOSS_CNT)))
            err_cnt_d = err_cnt_q + 1'b1;
          if (err_cnt_d == EC_W'(LOSS_CNT)) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      ph_q        <= '0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      is_comma_q  <= 1'b0;
      lock_q      <= 1'b0;
      realign_q   <= 1'b0;
      disp_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q     <= state_d;
      sr_q        <= sr_d;
      ph_q        <= ph_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sym_valid_q <= emit;
      is_comma_q  <= emit && match;
      lock_q      <= (state_d == LOCKED);
      realign_q   <= realign;
      disp_err_q  <= disp_err;
      if (emit) sym_q <= win;
    end
  end

  assign o_Sym       = sym_q;
  assign o_Sym_Valid = sym_valid_q;
  assign o_Is_Comma  = is_comma_q;
  assign o_Lock      = lock_q;
  assign o_Realign   = realign_q;
  assign o_Disp_Err  = disp_err_q;

endmodule

// File: tb/tb_sd_comma_aligner.sv
// Directed self-checking bench for sd_comma_aligner: acquisition, realign,
// loss of lock, valid gaps, disparity and asynchronous reset.
module tb_sd_comma_aligner;

  localparam logic [9:0] CN   = 10'b0011111010;
  localparam logic [9:0] CP   = 10'b1100000101;
  localparam logic [9:0] D215 = 10'b1010101010;
  localparam logic [9:0] DBAD = 10'b0111111000;

  logic       clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Bit = 1'b0;
  logic       i_Bit_Valid = 1'b0;
  logic [9:0] o_Sym;
  logic       o_Sym_Valid, o_Is_Comma, o_Lock, o_Realign, o_Disp_Err;

  typedef struct packed {
    logic [9:0] sym;
    logic       comma;
    logic       realign;
    logic       lock;
    logic       derr;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  sd_comma_aligner dut (
    .i_Clk       (clk),
    .i_Rst_n     (i_Rst_n),
    .i_Bit       (i_Bit),
    .i_Bit_Valid (i_Bit_Valid),
    .o_Sym       (o_Sym),
    .o_Sym_Valid (o_Sym_Valid),
    .o_Is_Comma  (o_Is_Comma),
    .o_Lock      (o_Lock),
    .o_Realign   (o_Realign),
    .o_Disp_Err  (o_Disp_Err)
  );

  // One valid bit; optional random idle cycles before it. Outputs sampled #1 after the edge.
  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) begin
        @(negedge clk);
        i_Bit       = 1'($urandom_range(0, 1));
        i_Bit_Valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_Sym_Valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_hold: o_Sym_Valid=%b during idle cycle, expected 0", o_Sym_Valid);
        end
      end
    end
    @(negedge clk);
    i_Bit       = b;
    i_Bit_Valid = 1'b1;
    @(posedge clk); #1;
    i_Bit_Valid = 1'b0;
    if (o_Sym_Valid === 1'b1)
      evq.push_back('{o_Sym, o_Is_Comma, o_Realign, o_Lock, o_Disp_Err});
  endtask

  task automatic send_range(input logic [9:0] s, input int hi, input int lo, input bit gaps);
    for (int i = hi; i >= lo; i--) send_bit(s[i], gaps);
  endtask

  task automatic send_sym(input logic [9:0] s, input bit gaps);
    send_range(s, 9, 0, gaps);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_Rst_n     = 1'b0;
    i_Bit_Valid = 1'b0;
    repeat (2) @(negedge clk);
    i_Rst_n = 1'b1;
    evq.delete();
  endtask

  // Junk, K28.5-, K28.5+, K28.5-, D21.5: acquire at bit 13, lock on third comma.
  task automatic acquire_seq(input bit gaps, input string tag);
    ev_t exp[4];
    exp[0] = '{CN,   1'b1, 1'b1, 1'b0, 1'b0};
    exp[1] = '{CP,   1'b1, 1'b0, 1'b0, 1'b0};
    exp[2] = '{CN,   1'b1, 1'b0, 1'b1, 1'b0};
    exp[3] = '{D215, 1'b0, 1'b0, 1'b1, 1'b0};
    send_bit(1'b1, gaps);
    send_bit(1'b0, gaps);
    send_bit(1'b1, gaps);
    send_range(CN, 9, 1, gaps);
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL %s_early: %0d symbols before bit 13, expected 0", tag, evq.size());
    end
    send_range(CN, 0, 0, gaps);
    checks++;
    if ({o_Sym_Valid, o_Is_Comma, o_Realign, o_Lock, o_Sym} !== {4'b1110, CN}) begin
      errors++;
      $display("FAIL %s_bit13: valid=%b comma=%b realign=%b lock=%b sym=%b, expected 1 1 1 0 %b",
               tag, o_Sym_Valid, o_Is_Comma, o_Realign, o_Lock, o_Sym, CN);
    end
    send_sym(CP, gaps);
    checks++;
    if (o_Lock !== 1'b0) begin
      errors++;
      $display("FAIL %s_lock2: o_Lock=%b after 2 commas, expected 0", tag, o_Lock);
    end
    send_sym(CN, gaps);
    checks++;
    if (o_Lock !== 1'b1) begin
      errors++;
      $display("FAIL %s_lock3: o_Lock=%b after 3 commas, expected 1", tag, o_Lock);
    end
    send_sym(D215, gaps);
    checks++;
    if (evq.size() != 4) begin
      errors++;
      $display("FAIL %s_count: %0d symbols, expected 4", tag, evq.size());
    end
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      checks++;
      if (evq[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_sym%0d: sym=%b comma=%b realign=%b lock=%b derr=%b, expected %b %b %b %b %b",
                 tag, i, evq[i].sym, evq[i].comma, evq[i].realign, evq[i].lock, evq[i].derr,
                 exp[i].sym, exp[i].comma, exp[i].realign, exp[i].lock, exp[i].derr);
      end
    end
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_Bit       = 1'($urandom_range(0, 1));
      i_Bit_Valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if ({o_Sym, o_Sym_Valid, o_Is_Comma, o_Lock, o_Realign, o_Disp_Err} !== 15'd0) begin
        errors++;
        $display("FAIL reset_outs: sym=%b valid=%b comma=%b lock=%b realign=%b derr=%b, expected all 0",
                 o_Sym, o_Sym_Valid, o_Is_Comma, o_Lock, o_Realign, o_Disp_Err);
      end
    end
    @(negedge clk);
    i_Bit_Valid = 1'b0;
    i_Rst_n     = 1'b1;
    evq.delete();
  endtask

  task automatic test_acquire_lock();
    acquire_seq(1'b0, "acq");
  endtask

  task automatic test_realign_sync();
    logic [12:0] exp[5];
    exp[0] = {CN,           1'b1, 1'b1, 1'b0};
    exp[1] = {10'b0110000010, 1'b0, 1'b0, 1'b0};
    exp[2] = {CP,           1'b1, 1'b1, 1'b0};
    exp[3] = {CN,           1'b1, 1'b0, 1'b0};
    exp[4] = {CP,           1'b1, 1'b0, 1'b1};
    apply_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_sym(CN, 1'b0);
    send_bit(1'b0, 1'b0);
    send_sym(CP, 1'b0);
    checks++;
    if ({o_Realign, o_Lock} !== 2'b10) begin
      errors++;
      $display("FAIL realign_pulse: realign=%b lock=%b, expected 1 0", o_Realign, o_Lock);
    end
    send_sym(CN, 1'b0);
    checks++;
    if (o_Lock !== 1'b0) begin
      errors++;
      $display("FAIL realign_lock1: o_Lock=%b after 1 aligned comma, expected 0", o_Lock);
    end
    send_sym(CP, 1'b0);
    checks++;
    if (o_Lock !== 1'b1) begin
      errors++;
      $display("FAIL realign_lock2: o_Lock=%b after 2 aligned commas, expected 1", o_Lock);
    end
    checks++;
    if (evq.size() != 5) begin
      errors++;
      $display("FAIL realign_count: %0d symbols, expected 5", evq.size());
    end
    for (int i = 0; i < 5 && i < evq.size(); i++) begin
      checks++;
      if ({evq[i].sym, evq[i].comma, evq[i].realign, evq[i].lock} !== exp[i]) begin
        errors++;
        $display("FAIL realign_sym%0d: got %b, expected %b", i,
                 {evq[i].sym, evq[i].comma, evq[i].realign, evq[i].lock}, exp[i]);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    logic [12:0] exp[5];
    exp[0] = {10'b0001111101, 1'b0, 1'b0, 1'b1};
    exp[1] = {10'b0000111110, 1'b0, 1'b0, 1'b1};
    exp[2] = {10'b1000011111, 1'b0, 1'b0, 1'b1};
    exp[3] = {10'b0100001111, 1'b0, 1'b0, 1'b1};
    exp[4] = {CP,             1'b1, 1'b1, 1'b0};
    apply_reset();
    acquire_seq(1'b0, "loss_pre");
    evq.delete();
    for (int k = 0; k < 4; k++) begin
      send_bit(1'b0, 1'b0);
      send_sym(CN, 1'b0);
      checks++;
      if (o_Lock !== ((k < 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL loss_lock%0d: o_Lock=%b after slip %0d, expected %b",
                 k, o_Lock, k + 1, (k < 3) ? 1'b1 : 1'b0);
      end
    end
    checks++;
    if (o_Sym_Valid !== 1'b0) begin
      errors++;
      $display("FAIL loss_reuse: o_Sym_Valid=%b on losing comma, expected 0", o_Sym_Valid);
    end
    send_sym(CP, 1'b0);
    checks++;
    if ({o_Sym_Valid, o_Realign, o_Lock} !== 3'b110) begin
      errors++;
      $display("FAIL loss_reacq: valid=%b realign=%b lock=%b, expected 1 1 0",
               o_Sym_Valid, o_Realign, o_Lock);
    end
    checks++;
    if (evq.size() != 5) begin
      errors++;
      $display("FAIL loss_count: %0d symbols, expected 5", evq.size());
    end
    for (int i = 0; i < 5 && i < evq.size(); i++) begin
      checks++;
      if ({evq[i].sym, evq[i].comma, evq[i].realign, evq[i].lock} !== exp[i]) begin
        errors++;
        $display("FAIL loss_sym%0d: got %b, expected %b", i,
                 {evq[i].sym, evq[i].comma, evq[i].realign, evq[i].lock}, exp[i]);
      end
    end
  endtask

  task automatic test_valid_gaps();
    apply_reset();
    acquire_seq(1'b1, "gap");
  endtask

  task automatic test_disparity();
    logic exp_derr;
`ifdef SD_RD_CHECK_EN
    exp_derr = 1'b1;
`else
    exp_derr = 1'b0;
`endif
    apply_reset();
    acquire_seq(1'b0, "disp_pre");
    send_sym(CP, 1'b0);
    evq.delete();
    send_sym(DBAD, 1'b0);
    send_sym(DBAD, 1'b0);
    checks++;
    if (evq.size() != 2) begin
      errors++;
      $display("FAIL disp_count: %0d symbols, expected 2", evq.size());
    end else begin
      checks++;
      if (evq[0] !== '{DBAD, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL disp_first: sym=%b comma=%b lock=%b derr=%b, expected %b 0 1 0",
                 evq[0].sym, evq[0].comma, evq[0].lock, evq[0].derr, DBAD);
      end
      checks++;
      if (evq[1] !== '{DBAD, 1'b0, 1'b0, 1'b1, exp_derr}) begin
        errors++;
        $display("FAIL disp_second: sym=%b comma=%b lock=%b derr=%b, expected %b 0 1 %b",
                 evq[1].sym, evq[1].comma, evq[1].lock, evq[1].derr, DBAD, exp_derr);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] d;
    d = D215;
    apply_reset();
    acquire_seq(1'b0, "arst_pre");
    send_range(d, 9, 6, 1'b0);
    @(negedge clk);
    i_Bit       = d[5];
    i_Bit_Valid = 1'b1;
    #2 i_Rst_n  = 1'b0;
    #1;
    i_Bit_Valid = 1'b0;
    checks++;
    if ({o_Lock, o_Sym_Valid, o_Sym} !== 12'd0) begin
      errors++;
      $display("FAIL arst_immediate: lock=%b valid=%b sym=%b, expected all 0", o_Lock, o_Sym_Valid, o_Sym);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({o_Lock, o_Sym_Valid} !== 2'b00) begin
        errors++;
        $display("FAIL arst_hold: lock=%b valid=%b, expected 0 0", o_Lock, o_Sym_Valid);
      end
    end
    @(negedge clk);
    i_Rst_n = 1'b1;
    evq.delete();
    acquire_seq(1'b0, "arst");
  endtask

  initial begin
    test_reset();
    test_acquire_lock();
    test_realign_sync();
    test_loss_of_lock();
    test_valid_gaps();
    test_disparity();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
